// File: rtl/pkt_fetch_ctrl_pkg.sv
// Shared definitions for the packet fetch controller: bus widths, reset
// polarity, FSM state encodings and the in-flight read tag.
package pkt_fetch_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH        = 32;
    localparam int unsigned DATA_WIDTH        = 32;
    localparam logic        RST_ENABLED       = 1'b1;
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;
    localparam int unsigned PKT_WORDS_DEFAULT = 64;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_ISSUE = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    // Travels alongside each outstanding RAM read until its data lands in the FIFO.
    typedef struct packed {
        logic vld;
        logic sop;
        logic eop;
    } fetch_tag_t;

endpackage

// File: rtl/pkt_fetch_fifo.sv
// Small synchronous FIFO with occupancy count; accepts a push and a pop in the
// same cycle, including when full. The head reads as zero while empty.
module pkt_fetch_fifo
    import pkt_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DATA_WIDTH + 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_data_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Next-state for storage, pointers and count; a full FIFO still takes a
    // push when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CNT_FULL) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/pkt_fetch_ctrl.sv
// Packet RAM read sequencer: takes a (start address, length) descriptor, walks
// the word index with wrap, and streams the returned words with SOP/EOP marks.
// The RAM's one-cycle read latency is covered by a 2-stage tag pipe feeding an
// output FIFO, so a packet streams at one word per cycle when not stalled.
module pkt_fetch_ctrl
    import pkt_fetch_ctrl_pkg::*;
#(
    parameter int unsigned PKT_WORDS  = PKT_WORDS_DEFAULT,
    parameter int unsigned LEN_WIDTH  = 7,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  start_len,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    localparam int unsigned IDX_W   = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WORD_W  = ADDR_WIDTH - 2;
    localparam int unsigned ENTRY_W = DATA_WIDTH + 2;

    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(PKT_WORDS - 1);
    localparam logic [WORD_W-1:0]    WORD_MOD  = WORD_W'(PKT_WORDS);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(PKT_WORDS);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [FCNT_W:0]      OCC_LIMIT = (FCNT_W + 1)'(FIFO_DEPTH);

    fetch_state_e          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    fetch_tag_t            tag0_q, tag0_d;
    fetch_tag_t            tag1_q, tag1_d;
    logic                  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;

    logic [WORD_W-1:0]     start_word, start_mod;
    logic [IDX_W-1:0]      start_idx;
    logic [LEN_WIDTH-1:0]  len_clamped;
    logic [1:0]            inflight;
    logic [FCNT_W:0]       occupancy;
    logic                  can_issue, drain_done;
    logic                  issue, issue_sop, issue_eop;
    logic [IDX_W-1:0]      issue_idx;

    logic                  fifo_push, fifo_pop, fifo_empty;
    logic [FCNT_W-1:0]     fifo_count;
    logic [ENTRY_W-1:0]    fifo_push_data, fifo_head;

    // Byte-offset bits of the start address carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^start_addr[1:0];

    assign start_ready = (state_q == FETCH_IDLE) && (rst != RST_ENABLED);
    assign start_word  = start_addr[ADDR_WIDTH-1:2];
    assign start_mod   = start_word % WORD_MOD;
    assign start_idx   = start_mod[IDX_W-1:0];
    assign len_clamped = (start_len > MAX_LEN) ? MAX_LEN : start_len;

    assign inflight  = {1'b0, tag0_q.vld} + {1'b0, tag1_q.vld};
    assign occupancy = {1'b0, fifo_count} + (FCNT_W + 1)'(inflight);
    // Registered occupancy only; a same-cycle pop does not open a slot early.
    assign can_issue = (occupancy < OCC_LIMIT);

    assign fifo_pop   = out_valid && out_ready;
    assign fifo_push  = tag1_q.vld;
    assign fifo_push_data = {tag1_q.sop, tag1_q.eop, ram_data_i};
    // Leave DRAIN on the edge that pops the last word so IDLE follows at once.
    assign drain_done = (inflight == 2'd0) &&
                        ((fifo_count == '0) || ((fifo_count == FCNT_W'(1)) && fifo_pop));

    // Sequencer next-state: the accept cycle issues the first read directly.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        ram_addr_d  = ram_addr_q;
        pkt_cnt_d   = pkt_cnt_q;
        tag1_d      = tag0_q;
        tag0_d      = '0;
        issue       = 1'b0;
        issue_idx   = idx_q;
        issue_sop   = 1'b0;
        issue_eop   = 1'b0;
        unique case (state_q)
            FETCH_IDLE: begin
                if (start_valid && start_ready && (len_clamped != '0)) begin
                    issue       = 1'b1;
                    issue_idx   = start_idx;
                    issue_sop   = 1'b1;
                    issue_eop   = (len_clamped == LEN_ONE);
                    remaining_d = len_clamped - LEN_ONE;
                    state_d     = issue_eop ? FETCH_DRAIN : FETCH_ISSUE;
                end
            end
            FETCH_ISSUE: begin
                if (can_issue) begin
                    issue       = 1'b1;
                    issue_eop   = (remaining_q == LEN_ONE);
                    remaining_d = remaining_q - LEN_ONE;
                    if (issue_eop) begin
                        state_d = FETCH_DRAIN;
                    end
                end
            end
            FETCH_DRAIN: begin
                if (drain_done) begin
                    state_d   = FETCH_IDLE;
                    pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
        if (issue) begin
            ram_addr_d             = '0;
            ram_addr_d[IDX_W+1:2]  = issue_idx;
            idx_d                  = (issue_idx == IDX_LAST) ? '0 : issue_idx + IDX_W'(1);
            tag0_d                 = '{vld: 1'b1, sop: issue_sop, eop: issue_eop};
        end
        busy_d = (state_d != FETCH_IDLE);
    end

    // FSM, tag pipe and registered outputs.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            state_q     <= FETCH_IDLE;
            idx_q       <= '0;
            remaining_q <= '0;
            ram_addr_q  <= '0;
            tag0_q      <= '0;
            tag1_q      <= '0;
            busy_q      <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            ram_addr_q  <= ram_addr_d;
            tag0_q      <= tag0_d;
            tag1_q      <= tag1_d;
            busy_q      <= busy_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    pkt_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .head_data_o (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign ram_addr_o = ram_addr_q;
    assign busy       = busy_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign out_valid  = !fifo_empty;
    assign out_sop    = fifo_head[ENTRY_W-1];
    assign out_eop    = fifo_head[ENTRY_W-2];
    assign out_data   = fifo_head[DATA_WIDTH-1:0];

endmodule
